// File: rtl/mips_iter_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// with valid/ready on the request and result sides and a synchronous cancel.
module mips_iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div_valid,
  output logic                  div_ready,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  cancel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] D_ZERO   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] D_ONES   = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_count;
  logic [DATA_WIDTH-1:0]   r_prem;
  logic [DATA_WIDTH-1:0]   r_quo;
  logic [DATA_WIDTH-1:0]   r_dvsr;
  logic [DATA_WIDTH-1:0]   r_dividend;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_dbz;
  logic [DATA_WIDTH-1:0]   r_quotient;
  logic [DATA_WIDTH-1:0]   r_remainder;
  logic                    r_div_by_zero;

  logic                    w_accept;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic [DATA_WIDTH:0]     w_shift;
  logic [DATA_WIDTH:0]     w_diff;
  logic                    w_take;
  logic [DATA_WIDTH-1:0]   w_prem_nxt;
  logic [DATA_WIDTH-1:0]   w_quo_nxt;
  logic [DATA_WIDTH-1:0]   w_q_final;
  logic [DATA_WIDTH-1:0]   w_r_final;

  function automatic logic [DATA_WIDTH-1:0] neg2c(input logic [DATA_WIDTH-1:0] v);
    return (~v) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; cancel forces IDLE from any state
  always_comb begin
    w_next_state = r_state;
    if (cancel) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = div_valid ? S_CALC : S_IDLE;
        S_CALC:  w_next_state = (r_count == CNT_LAST) ? S_DONE : S_CALC;
        S_DONE:  w_next_state = out_ready ? S_IDLE : S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    div_ready = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        div_ready = 1'b1;
        busy      = 1'b0;
      end
      S_CALC:  out_valid = 1'b0;
      S_DONE:  out_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && div_valid && !cancel;
  assign w_a_neg  = div_signed && dividend[DATA_WIDTH-1];
  assign w_b_neg  = div_signed && divisor[DATA_WIDTH-1];
  assign w_a_mag  = w_a_neg ? neg2c(dividend) : dividend;
  assign w_b_mag  = w_b_neg ? neg2c(divisor) : divisor;

  // Once the shifted remainder has its top bit set it exceeds any divisor;
  // otherwise a borrow shows up as bit DATA_WIDTH of the difference.
  assign w_shift    = {r_prem, r_quo[DATA_WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_take     = w_shift[DATA_WIDTH] | ~w_diff[DATA_WIDTH];
  assign w_prem_nxt = w_take ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
  assign w_quo_nxt  = {r_quo[DATA_WIDTH-2:0], w_take};

  assign w_q_final = r_dbz ? D_ONES : (r_neg_q ? neg2c(w_quo_nxt) : w_quo_nxt);
  assign w_r_final = r_dbz ? r_dividend : (r_neg_r ? neg2c(w_prem_nxt) : w_prem_nxt);

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= CNT_ZERO;
      r_prem        <= D_ZERO;
      r_quo         <= D_ZERO;
      r_dvsr        <= D_ZERO;
      r_dividend    <= D_ZERO;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_quotient    <= D_ZERO;
      r_remainder   <= D_ZERO;
      r_div_by_zero <= 1'b0;
    end else if (cancel) begin
      r_count <= CNT_ZERO;
    end else if (w_accept) begin
      r_count    <= CNT_ZERO;
      r_prem     <= D_ZERO;
      r_quo      <= w_a_mag;
      r_dvsr     <= w_b_mag;
      r_dividend <= dividend;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_dbz      <= (divisor == D_ZERO);
    end else if (r_state == S_CALC) begin
      r_prem <= w_prem_nxt;
      r_quo  <= w_quo_nxt;
      if (r_count == CNT_LAST) begin
        r_count       <= CNT_ZERO;
        r_quotient    <= w_q_final;
        r_remainder   <= w_r_final;
        r_div_by_zero <= r_dbz;
      end else begin
        r_count <= r_count + CNT_ONE;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
